// File: rtl/riscv_cpu_pkg.sv
// Shared types for the writeback stage: write-data source select, load size
// encoding, writeback FSM state and the latched load control word.
package riscv_cpu_pkg;

    localparam int unsigned WDATA_MUX_WIDTH = 2;
    localparam int unsigned LSU_SIZE_WIDTH  = 2;

    typedef enum logic [WDATA_MUX_WIDTH-1:0] {
        WDATA_ALU = 2'd0,
        WDATA_MEM = 2'd1,
        WDATA_PC  = 2'd2,
        WDATA_CSR = 2'd3
    } wdata_mux_e;

    typedef enum logic [LSU_SIZE_WIDTH-1:0] {
        LSU_BYTE  = 2'd0,
        LSU_HALF  = 2'd1,
        LSU_WORD  = 2'd2,
        LSU_DWORD = 2'd3
    } lsu_size_e;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

    // Load shape captured at accept time and held while waiting for the response.
    typedef struct packed {
        lsu_size_e size;
        logic      zero_ext;
    } lsu_ctl_t;

endpackage

// File: rtl/wb_unit_if.sv
// MEM-stage / memory-response / register-file bundle seen by the writeback unit.
interface wb_unit_if
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) ();

    localparam int unsigned OFFS_WIDTH = $clog2(DATA_WIDTH / 8);

    logic                       valid_i;
    logic                       ready_o;
    logic                       reg_we_i;
    logic [REG_ADDR_WIDTH-1:0]  dest_reg_i;
    logic [WDATA_MUX_WIDTH-1:0] wdata_mux_i;
    logic [DATA_WIDTH-1:0]      alu_result_i;
    logic [DATA_WIDTH-1:0]      pc_next_i;
    logic [DATA_WIDTH-1:0]      csr_rdata_i;
    logic [LSU_SIZE_WIDTH-1:0]  lsu_size_i;
    logic                       lsu_unsigned_i;
    logic [OFFS_WIDTH-1:0]      lsu_offset_i;
    logic                       mem_rvalid_i;
    logic [DATA_WIDTH-1:0]      mem_rdata_i;
    logic                       mem_err_i;
    logic [DATA_WIDTH-1:0]      wdata_o;
    logic [REG_ADDR_WIDTH-1:0]  dest_reg_o;
    logic                       we_o;
    logic                       busy_o;
    logic                       load_err_o;

    modport master (
        output valid_i, reg_we_i, dest_reg_i, wdata_mux_i,
               alu_result_i, pc_next_i, csr_rdata_i,
               lsu_size_i, lsu_unsigned_i, lsu_offset_i,
               mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  ready_o, wdata_o, dest_reg_o, we_o, busy_o, load_err_o
    );

    modport slave (
        input  valid_i, reg_we_i, dest_reg_i, wdata_mux_i,
               alu_result_i, pc_next_i, csr_rdata_i,
               lsu_size_i, lsu_unsigned_i, lsu_offset_i,
               mem_rvalid_i, mem_rdata_i, mem_err_i,
        output ready_o, wdata_o, dest_reg_o, we_o, busy_o, load_err_o
    );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load data alignment: shift the addressed bytes down to bit 0,
// keep the requested size and sign- or zero-extend to the full data width.
module wb_load_align
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]               rdata,
    input  lsu_size_e                           size,
    input  logic                                zero_ext,
    input  logic [$clog2(DATA_WIDTH / 8)-1:0]   offset,
    output logic [DATA_WIDTH-1:0]               data_c
);

    localparam int unsigned OFFS_WIDTH = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic                  sign;
    lsu_size_e             eff_size;

    // A doubleword request on a 32-bit datapath degrades to a word.
    always_comb begin
        eff_size = size;
        if ((DATA_WIDTH == 32) && (size == LSU_DWORD)) begin
            eff_size = LSU_WORD;
        end
    end

    // Bytes shifted in from beyond the word are zero; cross-word loads are not handled.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        mask    = '1;
        sign    = shifted[DATA_WIDTH-1];
        case (eff_size)
            LSU_BYTE: begin
                mask = DATA_WIDTH'(8'hFF);
                sign = shifted[7];
            end
            LSU_HALF: begin
                mask = DATA_WIDTH'(16'hFFFF);
                sign = shifted[15];
            end
            LSU_WORD: begin
                mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = shifted[DATA_WIDTH-1];
            end
        endcase
        data_c = (shifted & mask) | ({DATA_WIDTH{sign & ~zero_ext}} & ~mask);
    end

    logic unused_offs;
    assign unused_offs = (OFFS_WIDTH == 0);

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: retires ALU/PC/CSR results with one-cycle latency and waits
// for load responses. Define WB_LOAD_TIMEOUT_EN to bound the load wait.
module wb_unit
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned LOAD_TIMEOUT   = 16
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    wb_unit_if.slave bus
);

    localparam int unsigned OFFS_WIDTH = $clog2(DATA_WIDTH / 8);

    if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64)) || (LOAD_TIMEOUT < 1)) begin : g_param_check
        $error("wb_unit: DATA_WIDTH must be 32 or 64 and LOAD_TIMEOUT at least 1");
    end

    wb_state_e                 state;
    logic                      ready_q;
    logic                      busy_q;
    logic                      we_q;
    logic                      load_err_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;

    logic [REG_ADDR_WIDTH-1:0] ld_dest;
    logic                      ld_we;
    lsu_ctl_t                  ld_ctl;
    logic [OFFS_WIDTH-1:0]     ld_offset;

    logic                      accept_c;
    logic                      is_load_c;
    logic [DATA_WIDTH-1:0]     sel_data_c;
    logic [DATA_WIDTH-1:0]     aligned_c;

    assign accept_c  = bus.valid_i && ready_q;
    assign is_load_c = (wdata_mux_e'(bus.wdata_mux_i) == WDATA_MEM);

    // Non-load write data source.
    always_comb begin
        sel_data_c = bus.alu_result_i;
        case (wdata_mux_e'(bus.wdata_mux_i))
            WDATA_PC:  sel_data_c = bus.pc_next_i;
            WDATA_CSR: sel_data_c = bus.csr_rdata_i;
            default:   sel_data_c = bus.alu_result_i;
        endcase
    end

    wb_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .rdata    (bus.mem_rdata_i),
        .size     (ld_ctl.size),
        .zero_ext (ld_ctl.zero_ext),
        .offset   (ld_offset),
        .data_c   (aligned_c)
    );

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(LOAD_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             expire_c;
    // Expiry is the last WAIT_MEM cycle of the budget; a response in it still wins.
    assign expire_c = (tmo_cnt == TMO_W'(LOAD_TIMEOUT - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= WB_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            load_err_q <= 1'b0;
            wdata_q    <= '0;
            dest_q     <= '0;
            ld_dest    <= '0;
            ld_we      <= 1'b0;
            ld_ctl     <= '0;
            ld_offset  <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            we_q       <= 1'b0;
            load_err_q <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (accept_c && is_load_c) begin
                        state     <= WB_WAIT_MEM;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        ld_dest   <= bus.dest_reg_i;
                        ld_we     <= bus.reg_we_i;
                        ld_ctl    <= '{size: lsu_size_e'(bus.lsu_size_i), zero_ext: bus.lsu_unsigned_i};
                        ld_offset <= bus.lsu_offset_i;
`ifdef WB_LOAD_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end else if (accept_c && bus.reg_we_i && (bus.dest_reg_i != '0)) begin
                        we_q    <= 1'b1;
                        wdata_q <= sel_data_c;
                        dest_q  <= bus.dest_reg_i;
                    end
                end
                WB_WAIT_MEM: begin
                    if (bus.mem_rvalid_i) begin
                        state   <= WB_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        if (bus.mem_err_i) begin
                            load_err_q <= 1'b1;
                        end else if (ld_we && (ld_dest != '0)) begin
                            we_q    <= 1'b1;
                            wdata_q <= aligned_c;
                            dest_q  <= ld_dest;
                        end
`ifdef WB_LOAD_TIMEOUT_EN
                    end else if (expire_c) begin
                        state      <= WB_IDLE;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        load_err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end
                default: begin
                    state   <= WB_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.busy_o     = busy_q;
    assign bus.we_o       = we_q;
    assign bus.load_err_o = load_err_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.dest_reg_o = dest_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit (32-bit datapath); the timeout steps run only
// when WB_LOAD_TIMEOUT_EN is defined, otherwise an unbounded wait is checked.
module tb_wb_unit;
    import riscv_cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    wb_unit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    wb_unit #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .LOAD_TIMEOUT   (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.valid_i        = 1'b0;
        bus.reg_we_i       = 1'b0;
        bus.dest_reg_i     = '0;
        bus.wdata_mux_i    = WDATA_ALU;
        bus.alu_result_i   = '0;
        bus.pc_next_i      = '0;
        bus.csr_rdata_i    = '0;
        bus.lsu_size_i     = '0;
        bus.lsu_unsigned_i = 1'b0;
        bus.lsu_offset_i   = '0;
        bus.mem_rvalid_i   = 1'b0;
        bus.mem_rdata_i    = '0;
        bus.mem_err_i      = 1'b0;
    endtask

    task automatic issue_load(input logic [4:0] dest, input logic [1:0] size,
                              input logic uns, input logic [1:0] offs);
        bus.valid_i        = 1'b1;
        bus.reg_we_i       = 1'b1;
        bus.wdata_mux_i    = WDATA_MEM;
        bus.dest_reg_i     = dest;
        bus.lsu_size_i     = size;
        bus.lsu_unsigned_i = uns;
        bus.lsu_offset_i   = offs;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = rdata;
        bus.mem_err_i    = err;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_err_i    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_busy",  64'(bus.busy_o), 64'd0);
        chk("rst_we",    64'(bus.we_o), 64'd0);
        chk("rst_err",   64'(bus.load_err_o), 64'd0);
        chk("rst_wdata", 64'(bus.wdata_o), 64'd0);
        chk("rst_dest",  64'(bus.dest_reg_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // ALU op, latency 1
        bus.valid_i = 1'b1; bus.reg_we_i = 1'b1; bus.wdata_mux_i = WDATA_ALU;
        bus.alu_result_i = 32'h1234; bus.dest_reg_i = 5'd7;
        tick();
        bus.valid_i = 1'b0;
        chk("alu_we",    64'(bus.we_o), 64'd1);
        chk("alu_wdata", 64'(bus.wdata_o), 64'h1234);
        chk("alu_dest",  64'(bus.dest_reg_o), 64'd7);
        tick();
        chk("alu_we_pulse", 64'(bus.we_o), 64'd0);
        chk("alu_hold",     64'(bus.wdata_o), 64'h1234);

        // Back-to-back PC, CSR, then no-write and x0 ops
        bus.valid_i = 1'b1; bus.wdata_mux_i = WDATA_PC; bus.pc_next_i = 32'hAAAA_0004; bus.dest_reg_i = 5'd3;
        tick();
        chk("pc_we",    64'(bus.we_o), 64'd1);
        chk("pc_wdata", 64'(bus.wdata_o), 64'hAAAA_0004);
        chk("pc_dest",  64'(bus.dest_reg_o), 64'd3);
        bus.wdata_mux_i = WDATA_CSR; bus.csr_rdata_i = 32'h0000_C5C5; bus.dest_reg_i = 5'd9;
        tick();
        chk("csr_we",    64'(bus.we_o), 64'd1);
        chk("csr_wdata", 64'(bus.wdata_o), 64'h0000_C5C5);
        chk("csr_dest",  64'(bus.dest_reg_o), 64'd9);
        bus.wdata_mux_i = WDATA_ALU; bus.alu_result_i = 32'hDEAD; bus.dest_reg_i = 5'd5; bus.reg_we_i = 1'b0;
        tick();
        chk("nowe_we",   64'(bus.we_o), 64'd0);
        chk("nowe_hold", 64'(bus.wdata_o), 64'h0000_C5C5);
        bus.reg_we_i = 1'b1; bus.dest_reg_i = 5'd0;
        tick();
        bus.valid_i = 1'b0;
        chk("x0_we",   64'(bus.we_o), 64'd0);
        chk("x0_dest", 64'(bus.dest_reg_o), 64'd9);

        // rvalid while idle is ignored
        respond(32'hFFFF_FFFF, 1'b0);
        chk("idle_rvalid_we",   64'(bus.we_o), 64'd0);
        chk("idle_rvalid_busy", 64'(bus.busy_o), 64'd0);

        // Signed byte load, response 3 cycles after accept; ALU op waits behind it
        issue_load(5'd10, 2'd0, 1'b0, 2'd2);
        chk("sb_ready0", 64'(bus.ready_o), 64'd0);
        chk("sb_busy",   64'(bus.busy_o), 64'd1);
        tick();
        chk("sb_ready1", 64'(bus.ready_o), 64'd0);
        tick();
        chk("sb_ready2", 64'(bus.ready_o), 64'd0);
        bus.valid_i = 1'b1; bus.wdata_mux_i = WDATA_ALU; bus.alu_result_i = 32'h55; bus.dest_reg_i = 5'd4;
        respond(32'h0080_FF00, 1'b0);
        chk("sb_we",    64'(bus.we_o), 64'd1);
        chk("sb_wdata", 64'(bus.wdata_o), 64'hFFFF_FF80);
        chk("sb_dest",  64'(bus.dest_reg_o), 64'd10);
        chk("sb_ready", 64'(bus.ready_o), 64'd1);
        tick();
        bus.valid_i = 1'b0;
        chk("after_ld_wdata", 64'(bus.wdata_o), 64'h55);
        chk("after_ld_dest",  64'(bus.dest_reg_o), 64'd4);

        // Unsigned half load at offset 2, then same load to x0
        issue_load(5'd11, 2'd1, 1'b1, 2'd2);
        respond(32'h8001_ABCD, 1'b0);
        chk("lhu_we",    64'(bus.we_o), 64'd1);
        chk("lhu_wdata", 64'(bus.wdata_o), 64'h0000_8001);
        issue_load(5'd0, 2'd1, 1'b1, 2'd2);
        respond(32'h8001_ABCD, 1'b0);
        chk("lhu_x0_we",   64'(bus.we_o), 64'd0);
        chk("lhu_x0_dest", 64'(bus.dest_reg_o), 64'd11);

        // Signed half at offset 0, and dword request degraded to word
        issue_load(5'd12, 2'd1, 1'b0, 2'd0);
        respond(32'h1234_F00D, 1'b0);
        chk("lh_wdata", 64'(bus.wdata_o), 64'hFFFF_F00D);
        issue_load(5'd13, 2'd3, 1'b0, 2'd0);
        respond(32'h8765_4321, 1'b0);
        chk("ld_as_lw_wdata", 64'(bus.wdata_o), 64'h8765_4321);
        chk("ld_as_lw_we",    64'(bus.we_o), 64'd1);

        // Error response
        issue_load(5'd14, 2'd2, 1'b0, 2'd0);
        respond(32'h1111_1111, 1'b1);
        chk("err_pulse", 64'(bus.load_err_o), 64'd1);
        chk("err_we",    64'(bus.we_o), 64'd0);
        chk("err_ready", 64'(bus.ready_o), 64'd1);
        tick();
        chk("err_pulse_end", 64'(bus.load_err_o), 64'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        // Timeout after 4 WAIT_MEM cycles
        issue_load(5'd15, 2'd2, 1'b0, 2'd0);
        tick(); tick();
        tick();
        chk("tmo_not_yet", 64'(bus.load_err_o), 64'd0);
        tick();
        chk("tmo_err",   64'(bus.load_err_o), 64'd1);
        chk("tmo_we",    64'(bus.we_o), 64'd0);
        chk("tmo_ready", 64'(bus.ready_o), 64'd1);
        // Response on the expiry cycle wins
        issue_load(5'd16, 2'd2, 1'b0, 2'd0);
        tick(); tick(); tick();
        respond(32'hCAFE_F00D, 1'b0);
        chk("tmo_race_we",    64'(bus.we_o), 64'd1);
        chk("tmo_race_err",   64'(bus.load_err_o), 64'd0);
        chk("tmo_race_wdata", 64'(bus.wdata_o), 64'hCAFE_F00D);
`else
        // No timeout: the load waits past any budget
        issue_load(5'd15, 2'd2, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("wait_busy", 64'(bus.busy_o), 64'd1);
        chk("wait_err",  64'(bus.load_err_o), 64'd0);
        respond(32'hCAFE_F00D, 1'b0);
        chk("wait_wdata", 64'(bus.wdata_o), 64'hCAFE_F00D);
`endif

        // Reset while waiting: immediate reset values, late response dropped
        issue_load(5'd17, 2'd2, 1'b0, 2'd0);
        chk("pre_rst_busy", 64'(bus.busy_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  64'(bus.busy_o), 64'd0);
        chk("arst_ready", 64'(bus.ready_o), 64'd1);
        chk("arst_wdata", 64'(bus.wdata_o), 64'd0);
        chk("arst_dest",  64'(bus.dest_reg_o), 64'd0);
        tick();
        rst_n = 1'b1;
        respond(32'h7777_7777, 1'b0);
        chk("late_we",   64'(bus.we_o), 64'd0);
        chk("late_err",  64'(bus.load_err_o), 64'd0);
        chk("late_busy", 64'(bus.busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register/memory data width; legal values 32 or 64.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of the destination register index.
REQ-003 Parameter LOAD_TIMEOUT, default 16, maximum WAIT_MEM cycles; used only when the timeout macro is defined.
REQ-004 Localparam OFFS_WIDTH = log2(DATA_WIDTH/8), byte-offset width.
REQ-005 Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-006 clk_i  input  1  clock.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 valid_i  input  1  MEM stage presents an instruction.
REQ-009 ready_o  output  1  unit accepts an instruction this cycle.
REQ-010 reg_we_i  input  1  instruction writes a register.
REQ-011 dest_reg_i  input  REG_ADDR_WIDTH  destination register.
REQ-012 wdata_mux_i  input  WDATA_MUX_WIDTH  source select: WDATA_ALU, WDATA_MEM, WDATA_PC, WDATA_CSR.
REQ-013 alu_result_i / pc_next_i / csr_rdata_i  input  DATA_WIDTH each  candidate write data.
REQ-014 lsu_size_i  input  2  load size: 0 byte, 1 half, 2 word, 3 dword.
REQ-015 lsu_unsigned_i  input  1  zero-extend the load when 1, sign-extend when 0.
REQ-016 lsu_offset_i  input  OFFS_WIDTH  byte offset of the load within the data word.
REQ-017 mem_rvalid_i  input  1  load response valid.
REQ-018 mem_rdata_i  input  DATA_WIDTH  load response data.
REQ-019 mem_err_i  input  1  load response is an error; qualified by mem_rvalid_i.
REQ-020 wdata_o  output  DATA_WIDTH  register file write data.
REQ-021 dest_reg_o  output  REG_ADDR_WIDTH  register file write index.
REQ-022 we_o  output  1  register file write enable.
REQ-023 busy_o  output  1  high in WAIT_MEM.
REQ-024 load_err_o  output  1  one-cycle pulse flagging a failed load.

Function
REQ-025 Accept means valid_i && ready_o; ready_o is 1 in IDLE and 0 in WAIT_MEM.
REQ-026 FSM states are IDLE and WAIT_MEM.
REQ-027 IDLE transition: an accepted instruction with wdata_mux_i==WDATA_MEM moves the FSM to WAIT_MEM and latches dest_reg_i, reg_we_i, size, unsigned and offset.
REQ-028 Non-load accept: the selected ALU/PC/CSR data is registered; we_o=reg_we_i, wdata_o and dest_reg_o are valid in the cycle after accept (latency 1); the FSM stays in IDLE.
REQ-029 Back-to-back non-load accepts produce one write per cycle.
REQ-030 WAIT_MEM: mem_rvalid_i is ignored in IDLE and sampled only in WAIT_MEM.
REQ-031 WAIT_MEM response with mem_err_i=0: the aligned data is written the next cycle and the FSM returns to IDLE.
REQ-032 WAIT_MEM response with mem_err_i=1: we_o stays 0, load_err_o pulses the next cycle, and the FSM returns to IDLE.
REQ-033 Alignment: shift mem_rdata_i right by offset*8, keep size bytes, then sign- or zero-extend to DATA_WIDTH.
REQ-034 Size 3 with DATA_WIDTH=32 is treated as size 2.
REQ-035 Misalignment that crosses the data word is not handled; the bytes beyond the word are undefined.
REQ-036 we_o is forced to 0 when the latched destination is register 0.
REQ-037 we_o is a single-cycle pulse per retired instruction; wdata_o and dest_reg_o hold their last values when we_o=0.
REQ-038 The response cycle of a load never accepts a new instruction, because ready_o=0; the new accept happens the following cycle.

Reset
REQ-039 Asynchronous reset values: FSM=IDLE, we_o=0, load_err_o=0, wdata_o=0, dest_reg_o=0, busy_o=0, timeout counter=0.
REQ-040 Reset in WAIT_MEM drops the pending load with no write and no error pulse.

Configuration
REQ-041 Macro WB_LOAD_TIMEOUT_EN: when defined, a counter starts at 0 on entry to WAIT_MEM and increments each cycle without a response.
REQ-042 With the macro, reaching LOAD_TIMEOUT with no response pulses load_err_o, writes nothing and returns to IDLE.
REQ-043 With the macro, a response arriving in the same cycle as expiry takes priority, so the write is performed and no error is raised.
REQ-044 Without the macro, there is no counter logic and WAIT_MEM waits indefinitely.

Structure
REQ-045 The wdata_mux enum (WDATA_ALU, WDATA_MEM, WDATA_PC, WDATA_CSR), WDATA_MUX_WIDTH, the lsu_size enum and the FSM state typedef belong in riscv_cpu_pkg.
REQ-046 Alignment and extension is a combinational sub-module, wb_load_align.

Verification
REQ-047 ALU op: accept, WDATA_ALU, alu_result_i=0x1234, dest 7 -> next cycle we_o=1, wdata_o=0x00001234, dest_reg_o=7.
REQ-048 Signed byte load: offset 2, mem_rdata_i=0x0080FF00 returned 3 cycles after accept -> ready_o=0 for 3 cycles, then we_o=1 with wdata_o=0xFFFFFF80.
REQ-049 Unsigned half load: offset 2, rdata=0x8001ABCD -> wdata_o=0x00008001; with dest 0 the same load gives we_o=0.
REQ-050 Error response: mem_err_i=1 with rvalid -> load_err_o=1 for one cycle, we_o=0, ready_o=1 the next cycle.
REQ-051 Timeout (WB_LOAD_TIMEOUT_EN, LOAD_TIMEOUT=4): no rvalid -> load_err_o pulses after 4 WAIT_MEM cycles; a second run with rvalid in the expiry cycle -> write, no error.
REQ-052 Reset asserted in WAIT_MEM -> outputs take their reset values immediately; a late rvalid after release produces no write.
